// File: rtl/perceptron_trainer.sv
// Training sequencer for a single perceptron: buffers labelled samples, then
// replays them epoch by epoch until an error-free epoch or the epoch limit.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | not running; buffer may be loaded/cleared, outputs held at 0
// PRESENT   | sample idx on x/expected_y with train=1, y is compared
// SETTLE    | train=0, one cycle for the perceptron's delayed weight update
// EPOCH_END | epoch bookkeeping: converge, give up, or replay the buffer
module perceptron_trainer #(
   parameter int N     = 8,
   parameter int DEPTH = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [N-1:1]            load_x,
   input  logic [31:0]             load_exp_y,
   input  logic                    clear,
   input  logic                    start,
   input  logic [31:0]             learning_rate_in,
   input  logic [15:0]             max_epochs,
   output logic [N-1:1]            x,
   output logic                    train,
   output logic [31:0]             learning_rate,
   output logic [31:0]             expected_y,
   input  logic [31:0]             y,
   output logic                    busy,
   output logic                    done,
   output logic                    converged,
   output logic [15:0]             epoch_count,
   output logic [$clog2(DEPTH):0]  error_count
);

   localparam int IW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, PRESENT, SETTLE, EPOCH_END} state_t;

   state_t        state;
   logic [N-1:1]  mem_x [DEPTH];
   logic [31:0]   mem_y [DEPTH];
   logic [IW:0]   cnt;
   logic [IW-1:0] idx;
   logic [15:0]   limit;

   logic          load_ok;
   logic          clear_ok;
   logic          start_ok;
   logic [IW:0]   idx_next_ext;
   logic [IW-1:0] idx_next;
   logic [15:0]   epoch_next;

   assign load_ready   = !busy && (cnt < (IW+1)'(DEPTH));
   assign clear_ok     = clear && !busy;
   assign load_ok      = load_valid && load_ready && !clear;
   // a same-cycle clear empties the buffer, leaving the start nothing to train on
   assign start_ok     = start && !busy && (cnt != '0) && !clear;
   assign idx_next_ext = {1'b0, idx} + (IW+1)'(1);
   assign idx_next     = idx_next_ext[IW-1:0];
   assign epoch_next   = epoch_count + 16'd1;

   // sample buffer write port; contents survive runs and reset
   always_ff @(posedge clk) begin
      if (load_ok) begin
         mem_x[cnt[IW-1:0]] <= load_x;
         mem_y[cnt[IW-1:0]] <= load_exp_y;
      end
   end

   // sample count: clear wins over a same-cycle load
   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (clear_ok)
         cnt <= '0;
      else if (load_ok)
         cnt <= cnt + (IW+1)'(1);
   end

   // training sequencer with registered perceptron drive and status
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         idx           <= '0;
         limit         <= '0;
         x             <= '0;
         expected_y    <= '0;
         learning_rate <= '0;
         train         <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         converged     <= 1'b0;
         epoch_count   <= '0;
         error_count   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_ok) begin
                  learning_rate <= learning_rate_in;
                  limit         <= (max_epochs == 16'd0) ? 16'd1 : max_epochs;
                  done          <= 1'b0;
                  converged     <= 1'b0;
                  epoch_count   <= '0;
                  error_count   <= '0;
                  idx           <= '0;
                  x             <= mem_x[0];
                  expected_y    <= mem_y[0];
                  train         <= 1'b1;
                  busy          <= 1'b1;
                  state         <= PRESENT;
               end
            end
            PRESENT: begin
               train <= 1'b0;
               if (y != expected_y)
                  error_count <= error_count + (IW+1)'(1);
               state <= SETTLE;
            end
            SETTLE: begin
               if (idx_next_ext < cnt) begin
                  idx        <= idx_next;
                  x          <= mem_x[idx_next];
                  expected_y <= mem_y[idx_next];
                  train      <= 1'b1;
                  state      <= PRESENT;
               end else begin
                  state <= EPOCH_END;
               end
            end
            EPOCH_END: begin
               epoch_count <= epoch_next;
               if (error_count == '0 || epoch_next == limit) begin
                  converged     <= (error_count == '0);
                  done          <= 1'b1;
                  busy          <= 1'b0;
                  x             <= '0;
                  expected_y    <= '0;
                  learning_rate <= '0;
                  state         <= IDLE;
               end else begin
                  error_count <= '0;
                  idx         <= '0;
                  x           <= mem_x[0];
                  expected_y  <= mem_y[0];
                  train       <= 1'b1;
                  state       <= PRESENT;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
